// File: rtl/fscfg_pkg.sv
// Shared register-map constants and field helpers for the frame-synchronous
// configuration bank.
package fscfg_pkg;

    localparam int IDX_CTRL      = 0;
    localparam int IDX_ENABLE    = 1;
    localparam int IDX_STATUS    = 2;
    localparam int IDX_OUTSIZE   = 3;
    localparam int STREAM_BASE   = 4;
    localparam int STREAM_STRIDE = 5;
    localparam int NUM_SREG      = 5;

    localparam int W_OFS = 16;
    localparam int H_OFS = 0;

    localparam logic [31:0] CORE_VERSION = 32'hFF00FF01;

    typedef enum logic [2:0] {
        SR_SIZE    = 3'd0,
        SR_WINPOS  = 3'd1,
        SR_WINSIZE = 3'd2,
        SR_DSTPOS  = 3'd3,
        SR_DSTSIZE = 3'd4
    } stream_reg_e;

    // Position registers reset to 0 on every stream; size registers take the default.
    function automatic logic is_pos_reg(input int r);
        return (r == int'(SR_WINPOS)) || (r == int'(SR_DSTPOS));
    endfunction

    function automatic logic [31:0] pack_wh(input logic [15:0] w, input logic [15:0] h);
        logic [31:0] word;
        word = '0;
        word[W_OFS +: 16] = w;
        word[H_OFS +: 16] = h;
        return word;
    endfunction

endpackage

// File: rtl/fscfg_fsync_edge.sv
// Two-flop synchroniser for the asynchronous fsync input plus an edge flop;
// rise is high for exactly one clk cycle per fsync rising edge.
module fscfg_fsync_edge (
    input  logic clk,
    input  logic reset,
    input  logic fsync,
    output logic rise
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic edge_q,  edge_d;

    always_comb begin
        sync1_d = fsync;
        sync2_d = sync1_q;
        edge_d  = sync2_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            edge_q  <= edge_d;
        end
    end

    assign rise = sync2_q & ~edge_q;

endmodule

// File: rtl/fscfg_bank.sv
// Frame-synchronous configuration bank: host writes land in shadow registers
// and a commit moves them atomically into the active outputs on fsync.
module fscfg_bank
    import fscfg_pkg::*;
#(
    parameter logic [31:0] C_CORE_VERSION  = CORE_VERSION,
    parameter int          C_DATA_WIDTH    = 32,
    parameter int          C_REG_IDX_WIDTH = 8,
    parameter int          C_STREAM_NUM    = 3,
    parameter int          C_IMG_WBITS     = 12,
    parameter int          C_IMG_HBITS     = 12,
    parameter int          C_IMG_WDEF      = 320,
    parameter int          C_IMG_HDEF      = 240
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                rd_en,
    input  logic [C_REG_IDX_WIDTH-1:0]          rd_addr,
    output logic [C_DATA_WIDTH-1:0]             rd_data,
    input  logic                                wr_en,
    input  logic [C_REG_IDX_WIDTH-1:0]          wr_addr,
    input  logic [C_DATA_WIDTH-1:0]             wr_data,
    input  logic                                fsync,
    output logic                                o_fsync,
    output logic                                soft_resetn,
    output logic [C_IMG_WBITS-1:0]              out_width,
    output logic [C_IMG_HBITS-1:0]              out_height,
    output logic [C_STREAM_NUM-1:0]             s_soft_resetn,
    output logic [C_STREAM_NUM*C_IMG_WBITS-1:0] s_width,
    output logic [C_STREAM_NUM*C_IMG_HBITS-1:0] s_height,
    output logic [C_STREAM_NUM*C_IMG_WBITS-1:0] s_win_left,
    output logic [C_STREAM_NUM*C_IMG_HBITS-1:0] s_win_top,
    output logic [C_STREAM_NUM*C_IMG_WBITS-1:0] s_win_width,
    output logic [C_STREAM_NUM*C_IMG_HBITS-1:0] s_win_height,
    output logic [C_STREAM_NUM*C_IMG_WBITS-1:0] s_dst_left,
    output logic [C_STREAM_NUM*C_IMG_HBITS-1:0] s_dst_top,
    output logic [C_STREAM_NUM*C_IMG_WBITS-1:0] s_dst_width,
    output logic [C_STREAM_NUM*C_IMG_HBITS-1:0] s_dst_height
);

    localparam int N = C_STREAM_NUM;
    localparam int W = C_IMG_WBITS;
    localparam int H = C_IMG_HBITS;

    typedef logic [C_REG_IDX_WIDTH-1:0] idx_t;

    logic                 fsync_rise, apply;
    logic                 soft_resetn_q, soft_resetn_d;
    logic                 pending_q, pending_d;
    logic [N-1:0]         enable_q, enable_d;
    logic [15:0]          frame_cnt_q, frame_cnt_d;
    logic [15:0]          commit_cnt_q, commit_cnt_d;
    logic                 o_fsync_q, o_fsync_d;
    logic [W-1:0]         out_w_sh_q, out_w_sh_d, out_w_act_q, out_w_act_d;
    logic [H-1:0]         out_h_sh_q, out_h_sh_d, out_h_act_q, out_h_act_d;
    logic [N-1:0]         s_srst_q, s_srst_d;
    logic [C_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [31:0]          rd_word;
    logic [N-1:0][NUM_SREG-1:0][31:0] sh_word;
    logic                 unused_wr_data;

    assign unused_wr_data = ^wr_data;

    fscfg_fsync_edge u_fsync_edge (
        .clk   (clk),
        .reset (reset),
        .fsync (fsync),
        .rise  (fsync_rise)
    );

    assign apply = fsync_rise & pending_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        soft_resetn_d = soft_resetn_q;
        pending_d     = pending_q;
        enable_d      = enable_q;
        frame_cnt_d   = frame_cnt_q;
        commit_cnt_d  = commit_cnt_q;
        out_w_sh_d    = out_w_sh_q;
        out_h_sh_d    = out_h_sh_q;
        out_w_act_d   = out_w_act_q;
        out_h_act_d   = out_h_act_q;
        s_srst_d      = s_srst_q;
        o_fsync_d     = fsync_rise;

        if (fsync_rise) frame_cnt_d = frame_cnt_q + 16'd1;
        if (apply) begin
            pending_d    = 1'b0;
            commit_cnt_d = commit_cnt_q + 16'd1;
            out_w_act_d  = out_w_sh_q;
            out_h_act_d  = out_h_sh_q;
            s_srst_d     = enable_q;
        end

        // Host writes are evaluated after apply so a commit on the apply edge re-arms pending.
        if (wr_en) begin
            if (wr_addr == idx_t'(IDX_CTRL)) begin
                soft_resetn_d = wr_data[0];
                if (wr_data[1]) pending_d = 1'b1;
            end
            if (wr_addr == idx_t'(IDX_ENABLE)) enable_d = wr_data[N-1:0];
            if (wr_addr == idx_t'(IDX_OUTSIZE)) begin
                out_w_sh_d = wr_data[W_OFS +: W];
                out_h_sh_d = wr_data[H_OFS +: H];
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (rd_addr == idx_t'(IDX_CTRL))         rd_word = {30'd0, pending_q, soft_resetn_q};
        else if (rd_addr == idx_t'(IDX_ENABLE))  rd_word = 32'(enable_q);
        else if (rd_addr == idx_t'(IDX_STATUS))  rd_word = {commit_cnt_q, frame_cnt_q};
        else if (rd_addr == idx_t'(IDX_OUTSIZE)) rd_word = pack_wh(16'(out_w_sh_q), 16'(out_h_sh_q));
        else if (rd_addr == '1)                  rd_word = C_CORE_VERSION;
        for (int s = 0; s < N; s++) begin
            for (int r = 0; r < NUM_SREG; r++) begin
                if (rd_addr == idx_t'(STREAM_BASE + STREAM_STRIDE * s + r)) rd_word = sh_word[s][r];
            end
        end
        rd_data_d = rd_en ? C_DATA_WIDTH'(rd_word) : rd_data_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            soft_resetn_q <= 1'b0;
            pending_q     <= 1'b0;
            enable_q      <= N'(1);
            frame_cnt_q   <= '0;
            commit_cnt_q  <= '0;
            out_w_sh_q    <= W'(C_IMG_WDEF);
            out_h_sh_q    <= H'(C_IMG_HDEF);
            out_w_act_q   <= W'(C_IMG_WDEF);
            out_h_act_q   <= H'(C_IMG_HDEF);
            s_srst_q      <= '0;
            o_fsync_q     <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            soft_resetn_q <= soft_resetn_d;
            pending_q     <= pending_d;
            enable_q      <= enable_d;
            frame_cnt_q   <= frame_cnt_d;
            commit_cnt_q  <= commit_cnt_d;
            out_w_sh_q    <= out_w_sh_d;
            out_h_sh_q    <= out_h_sh_d;
            out_w_act_q   <= out_w_act_d;
            out_h_act_q   <= out_h_act_d;
            s_srst_q      <= s_srst_d;
            o_fsync_q     <= o_fsync_d;
            rd_data_q     <= rd_data_d;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_stream
        localparam logic [W-1:0] DEF_W = (g == 0) ? W'(C_IMG_WDEF) : '0;
        localparam logic [H-1:0] DEF_H = (g == 0) ? H'(C_IMG_HDEF) : '0;

        logic [W-1:0] sh_w_q [NUM_SREG];
        logic [W-1:0] sh_w_d [NUM_SREG];
        logic [H-1:0] sh_h_q [NUM_SREG];
        logic [H-1:0] sh_h_d [NUM_SREG];
        logic [W-1:0] act_w_q [NUM_SREG];
        logic [W-1:0] act_w_d [NUM_SREG];
        logic [H-1:0] act_h_q [NUM_SREG];
        logic [H-1:0] act_h_d [NUM_SREG];

        always_comb begin
            for (int r = 0; r < NUM_SREG; r++) begin
                sh_w_d[r]  = sh_w_q[r];
                sh_h_d[r]  = sh_h_q[r];
                act_w_d[r] = act_w_q[r];
                act_h_d[r] = act_h_q[r];
                if (apply) begin
                    act_w_d[r] = enable_q[g] ? sh_w_q[r] : '0;
                    act_h_d[r] = enable_q[g] ? sh_h_q[r] : '0;
                end
                if (wr_en && (wr_addr == idx_t'(STREAM_BASE + STREAM_STRIDE * g + r))) begin
                    sh_w_d[r] = wr_data[W_OFS +: W];
                    sh_h_d[r] = wr_data[H_OFS +: H];
                end
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                // NOTE: these register arrays are plain flops, not RAM, so they take a reset value.
                for (int r = 0; r < NUM_SREG; r++) begin
                    sh_w_q[r]  <= is_pos_reg(r) ? '0 : DEF_W;
                    sh_h_q[r]  <= is_pos_reg(r) ? '0 : DEF_H;
                    act_w_q[r] <= is_pos_reg(r) ? '0 : DEF_W;
                    act_h_q[r] <= is_pos_reg(r) ? '0 : DEF_H;
                end
            end else begin
                for (int r = 0; r < NUM_SREG; r++) begin
                    sh_w_q[r]  <= sh_w_d[r];
                    sh_h_q[r]  <= sh_h_d[r];
                    act_w_q[r] <= act_w_d[r];
                    act_h_q[r] <= act_h_d[r];
                end
            end
        end

        for (genvar r = 0; r < NUM_SREG; r++) begin : g_word
            assign sh_word[g][r] = pack_wh(16'(sh_w_q[r]), 16'(sh_h_q[r]));
        end

        assign s_width[g*W +: W]      = act_w_q[SR_SIZE];
        assign s_height[g*H +: H]     = act_h_q[SR_SIZE];
        assign s_win_left[g*W +: W]   = act_w_q[SR_WINPOS];
        assign s_win_top[g*H +: H]    = act_h_q[SR_WINPOS];
        assign s_win_width[g*W +: W]  = act_w_q[SR_WINSIZE];
        assign s_win_height[g*H +: H] = act_h_q[SR_WINSIZE];
        assign s_dst_left[g*W +: W]   = act_w_q[SR_DSTPOS];
        assign s_dst_top[g*H +: H]    = act_h_q[SR_DSTPOS];
        assign s_dst_width[g*W +: W]  = act_w_q[SR_DSTSIZE];
        assign s_dst_height[g*H +: H] = act_h_q[SR_DSTSIZE];
    end

    assign rd_data       = rd_data_q;
    assign o_fsync       = o_fsync_q;
    assign soft_resetn   = soft_resetn_q;
    assign out_width     = out_w_act_q;
    assign out_height    = out_h_act_q;
    assign s_soft_resetn = s_srst_q;

endmodule

// File: tb/tb_fscfg_bank.sv
// Self-checking bench for fscfg_bank: a register-map level model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_fscfg_bank;

    localparam int N  = 3;
    localparam int W  = 12;
    localparam int H  = 12;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam logic [31:0] VERSION   = 32'hFF00FF01;
    localparam logic [31:0] GEOM_MASK = 32'h0FFF_0FFF;
    localparam logic [31:0] DEF_SIZE  = 32'h0140_00F0;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic fsync = 1'b0;

    logic [DW-1:0]  rd_data;
    logic           o_fsync, soft_resetn;
    logic [W-1:0]   out_width;
    logic [H-1:0]   out_height;
    logic [N-1:0]   s_soft_resetn;
    logic [N*W-1:0] s_width, s_win_left, s_win_width, s_dst_left, s_dst_width;
    logic [N*H-1:0] s_height, s_win_top, s_win_height, s_dst_top, s_dst_height;

    always #5 clk = ~clk;

    fscfg_bank #(
        .C_CORE_VERSION  (VERSION),
        .C_DATA_WIDTH    (DW),
        .C_REG_IDX_WIDTH (AW),
        .C_STREAM_NUM    (N),
        .C_IMG_WBITS     (W),
        .C_IMG_HBITS     (H),
        .C_IMG_WDEF      (320),
        .C_IMG_HDEF      (240)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .fsync         (fsync),
        .o_fsync       (o_fsync),
        .soft_resetn   (soft_resetn),
        .out_width     (out_width),
        .out_height    (out_height),
        .s_soft_resetn (s_soft_resetn),
        .s_width       (s_width),
        .s_height      (s_height),
        .s_win_left    (s_win_left),
        .s_win_top     (s_win_top),
        .s_win_width   (s_win_width),
        .s_win_height  (s_win_height),
        .s_dst_left    (s_dst_left),
        .s_dst_top     (s_dst_top),
        .s_dst_width   (s_dst_width),
        .s_dst_height  (s_dst_height)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: register file indexed by register number.
    logic [31:0]  m_shadow [256];
    logic [31:0]  m_active [256];
    logic [N-1:0] m_srst;
    logic         m_pending, m_soft, m_ofs;
    logic [15:0]  m_frames, m_commits;
    logic [31:0]  m_rd;
    bit           m_fs [3];

    function automatic bit is_geom(input int idx);
        return (idx == 3) || (idx >= 4 && idx < 4 + 5 * N);
    endfunction

    function automatic logic [31:0] m_read(input int idx);
        if (idx == 0) return {30'd0, m_pending, m_soft};
        if (idx == 1 || is_geom(idx)) return m_shadow[idx];
        if (idx == 2) return {m_commits, m_frames};
        if (idx == 255) return VERSION;
        return '0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 256; i++) m_shadow[i] = '0;
        m_shadow[1] = 32'd1;
        m_shadow[3] = DEF_SIZE;
        m_shadow[4] = DEF_SIZE;
        m_shadow[6] = DEF_SIZE;
        m_shadow[8] = DEF_SIZE;
        for (int i = 0; i < 256; i++) m_active[i] = m_shadow[i];
        m_srst    = '0;
        m_pending = 1'b0;
        m_soft    = 1'b0;
        m_ofs     = 1'b0;
        m_frames  = '0;
        m_commits = '0;
        m_rd      = '0;
        for (int i = 0; i < 3; i++) m_fs[i] = 1'b0;
    endtask

    task automatic model_step();
        bit rise;
        int a;
        if (rd_en) m_rd = m_read(int'(rd_addr));
        // m_fs[k] holds the fsync sample taken k+1 edges ago; an edge seen two edges back applies now.
        rise  = m_fs[1] && !m_fs[2];
        m_ofs = rise;
        if (rise) begin
            m_frames++;
            if (m_pending) begin
                m_pending = 1'b0;
                m_commits++;
                m_active[3] = m_shadow[3];
                for (int s = 0; s < N; s++)
                    for (int r = 0; r < 5; r++)
                        m_active[4 + 5 * s + r] = m_shadow[1][s] ? m_shadow[4 + 5 * s + r] : 32'd0;
                m_srst = m_shadow[1][N-1:0];
            end
        end
        if (wr_en) begin
            a = int'(wr_addr);
            if (a == 0) begin
                m_soft = wr_data[0];
                if (wr_data[1]) m_pending = 1'b1;
            end else if (a == 1) begin
                m_shadow[1] = wr_data & 32'((1 << N) - 1);
            end else if (is_geom(a)) begin
                m_shadow[a] = wr_data & GEOM_MASK;
            end
        end
        m_fs[2] = m_fs[1];
        m_fs[1] = m_fs[0];
        m_fs[0] = fsync;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else       model_step();
    end

    always @(negedge clk) begin
        logic [N*W-1:0] e_w [5];
        logic [N*H-1:0] e_h [5];
        for (int r = 0; r < 5; r++) begin
            e_w[r] = '0;
            e_h[r] = '0;
            for (int s = 0; s < N; s++) begin
                e_w[r][s*W +: W] = m_active[4 + 5 * s + r][16 +: W];
                e_h[r][s*H +: H] = m_active[4 + 5 * s + r][0 +: H];
            end
        end
        check("o_fsync", o_fsync, m_ofs);
        check("soft_resetn", soft_resetn, m_soft);
        check("s_soft_resetn", s_soft_resetn, m_srst);
        check("rd_data", rd_data, m_rd);
        check("out_width", out_width, m_active[3][16 +: W]);
        check("out_height", out_height, m_active[3][0 +: H]);
        check("s_width", s_width, e_w[0]);
        check("s_height", s_height, e_h[0]);
        check("s_win_left", s_win_left, e_w[1]);
        check("s_win_top", s_win_top, e_h[1]);
        check("s_win_width", s_win_width, e_w[2]);
        check("s_win_height", s_win_height, e_h[2]);
        check("s_dst_left", s_dst_left, e_w[3]);
        check("s_dst_top", s_dst_top, e_h[3]);
        check("s_dst_width", s_dst_width, e_w[4]);
        check("s_dst_height", s_dst_height, e_h[4]);
    end

    task automatic wr(input int idx, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = AW'(idx);
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic rd(input int idx, output logic [31:0] d);
        rd_en   = 1'b1;
        rd_addr = AW'(idx);
        @(negedge clk);
        rd_en   = 1'b0;
        d       = rd_data;
    endtask

    task automatic fsync_pulse();
        fsync = 1'b1;
        repeat (3) @(negedge clk);
        fsync = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    function automatic logic [AW-1:0] rand_idx();
        case ($urandom_range(0, 9))
            0:       return AW'(255);
            1:       return AW'($urandom_range(0, 255));
            default: return AW'($urandom_range(0, 20));
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int fs_len;
        int fs_target;

        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset s_soft_resetn", s_soft_resetn, 0);
        check("reset o_fsync", o_fsync, 0);
        check("reset rd_data", rd_data, 0);
        reset = 1'b0;
        @(negedge clk);
        rd(3, d);   check("reset OUTSIZE read", d, 32'h0140_00F0);
        rd(2, d);   check("reset STATUS read", d, 32'h0);
        rd(255, d); check("version read", d, 32'hFF00_FF01);
        rd(40, d);  check("unmapped read", d, 32'h0);

        // Stream 1 size update through a commit.
        wr(9, 32'h0280_0168);
        wr(1, 32'd3);
        wr(0, 32'd3);
        fsync = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("o_fsync before apply", o_fsync, 0);
        check("s_width before apply", s_width[W +: W], 0);
        @(negedge clk);
        check("o_fsync at apply", o_fsync, 1);
        check("s1 width applied", s_width[W +: W], 640);
        check("s1 height applied", s_height[H +: H], 360);
        check("s_soft_resetn applied", s_soft_resetn, 3'b011);
        fsync = 1'b0;
        @(negedge clk);
        check("o_fsync one cycle", o_fsync, 0);
        repeat (2) @(negedge clk);
        rd(0, d); check("pending cleared", d[1], 0);
        rd(2, d); check("status after 1st apply", d, {16'd1, 16'd1});

        // Shadow write without commit changes nothing.
        wr(9, 32'h0100_0100);
        fsync_pulse();
        check("s1 width held", s_width[W +: W], 640);
        rd(2, d); check("status frame only", d, {16'd1, 16'd2});

        // Disable stream 1.
        wr(0, 32'd3);
        wr(1, 32'd1);
        wr(0, 32'd3);
        fsync_pulse();
        check("s1 width disabled", s_width[W +: W], 0);
        check("s1 dst_width disabled", s_dst_width[W +: W], 0);
        check("s0 width kept", s_width[0 +: W], 320);
        check("s_soft_resetn disabled", s_soft_resetn, 3'b001);

        // Commit written on the apply edge.
        wr(1, 32'd7);
        wr(0, 32'd3);
        fsync = 1'b1;
        @(negedge clk);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = AW'(0); wr_data = 32'd3;
        @(negedge clk);
        wr_en = 1'b0;
        check("o_fsync on commit edge", o_fsync, 1);
        check("s_soft_resetn all", s_soft_resetn, 3'b111);
        fsync = 1'b0;
        rd(0, d); check("pending re-armed", d[1], 1);
        wr(14, 32'h0040_0030);
        repeat (2) @(negedge clk);
        fsync_pulse();
        check("s2 width second apply", s_width[2*W +: W], 64);
        check("s2 height second apply", s_height[2*H +: H], 48);
        rd(2, d); check("status after re-arm", d, {16'd4, 16'd5});

        // Reset with pending set in the middle of an fsync.
        wr(0, 32'd3);
        fsync = 1'b1;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async reset o_fsync", o_fsync, 0);
        check("async reset soft_resetn", soft_resetn, 0);
        check("async reset s_soft_resetn", s_soft_resetn, 0);
        check("async reset rd_data", rd_data, 0);
        check("async reset out_width", out_width, 320);
        check("async reset s_width", s_width, 36'd320);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        fsync = 1'b0;
        repeat (3) @(negedge clk);
        check("post reset no apply srst", s_soft_resetn, 0);
        check("post reset no apply width", s_width, 36'd320);
        rd(2, d); check("post reset status", d, {16'd0, 16'd1});

        // Randomized traffic against the model.
        fs_len    = 0;
        fs_target = 3;
        for (int c = 0; c < 3000; c++) begin
            rd_en   = 1'($urandom_range(0, 1));
            rd_addr = rand_idx();
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_addr = rand_idx();
            wr_data = $urandom();
            fs_len++;
            if (fs_len >= fs_target) begin
                fsync     = ~fsync;
                fs_len    = 0;
                fs_target = $urandom_range(2, 12);
            end
            @(negedge clk);
        end
        rd_en = 1'b0;
        wr_en = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
